sonic_rx_ring_ctl: RTL and testbench

Parametrised single-clock RX ring controller that replaces the fixed-size 66-bit receive buffer control for lanes where PCS and DMA share one clock domain. Holds DATA_W-bit blocks from the gearbox/block-sync path in a 2^ADDR_W-entry ring and keeps it safe against overflow and underflow. Exports occupancy, thresholds and the write pointer toward the IRQ/DMA logic. Adds selectable overwrite-oldest mode, a saturating overflow counter and a chunk-complete interrupt pulse.

---
 rtl/sonic_rx_ring_ctl.sv | 161 ++++++++++++++++
 tb/tb_sonic_rx_ring_ctl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sonic_rx_ring_ctl.sv
// Single-clock RX block ring: gearbox writes, DMA reads, with occupancy flags,
// overflow accounting and a per-chunk write interrupt.
module sonic_rx_ring_ctl #(
  parameter int unsigned DATA_W    = 66,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned AFULL_TH  = (2 ** ADDR_W) - 8,
  parameter int unsigned AEMPTY_TH = 8,
  parameter int unsigned CHUNK     = 32,
  parameter bit          OVERWRITE = 1'b0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              wrena,
  input  logic              wrreq,
  input  logic              rdena,
  input  logic              rdreq,
  input  logic              clear_ovf,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic [ADDR_W:0]   usedw,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   wptr,
  output logic [ADDR_W:0]   rptr,
  output logic              irq,
  output logic [15:0]       ovf_count
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef logic [ADDR_W:0] ptr_t;

  localparam ptr_t DEPTH_V    = ptr_t'(DEPTH);
  localparam ptr_t AFULL_V    = ptr_t'(AFULL_TH);
  localparam ptr_t AEMPTY_V   = ptr_t'(AEMPTY_TH);
  localparam ptr_t CHUNK_LAST = ptr_t'(CHUNK - 1);
  localparam ptr_t PTR_ONE    = ptr_t'(1);

  logic [DATA_W-1:0] mem_q [DEPTH];

  ptr_t              wptr_q,  wptr_d;
  ptr_t              rptr_q,  rptr_d;
  ptr_t              usedw_q, usedw_d;
  ptr_t              chunk_q, chunk_d;
  logic [DATA_W-1:0] dout_q,  dout_d;
  logic              dv_q,    dv_d;
  logic              irq_q,   irq_d;
  logic [15:0]       ovf_q,   ovf_d;

  logic full_w;
  logic empty_w;
  logic wr_try;
  logic rd_ok;
  logic wr_ok;
  logic evict;
  logic drop;

  // Flags decode straight from the registered occupancy counter.
  assign full_w  = (usedw_q == DEPTH_V);
  assign empty_w = (usedw_q == '0);

  assign wr_try = wrena & wrreq;
  assign rd_ok  = rdena & rdreq & ~empty_w;
  assign wr_ok  = wr_try & (~full_w | rd_ok | OVERWRITE);
  // Overwrite of a full ring: the oldest entry is discarded in place.
  assign evict  = wr_ok & full_w & ~rd_ok;
  assign drop   = wr_try & ~wr_ok;

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    usedw_d = usedw_q;
    chunk_d = chunk_q;
    dout_d  = dout_q;
    dv_d    = rd_ok;
    irq_d   = 1'b0;
    ovf_d   = ovf_q;

    if (wr_ok) begin
      wptr_d = wptr_q + PTR_ONE;
    end
    if (rd_ok || evict) begin
      rptr_d = rptr_q + PTR_ONE;
    end

    if (wr_ok && !rd_ok && !evict) begin
      usedw_d = usedw_q + PTR_ONE;
    end else if (rd_ok && !wr_ok) begin
      usedw_d = usedw_q - PTR_ONE;
    end

    // The read sees the RAM before this edge's write, so a same-slot write never bypasses.
    if (rd_ok) begin
      dout_d = mem_q[rptr_q[ADDR_W-1:0]];
    end

    if (!wrena) begin
      chunk_d = '0;
    end else if (wr_ok) begin
      if (chunk_q == CHUNK_LAST) begin
        chunk_d = '0;
        irq_d   = 1'b1;
      end else begin
        chunk_d = chunk_q + PTR_ONE;
      end
    end

    if (clear_ovf) begin
      ovf_d = '0;
    end else if ((drop || evict) && (ovf_q != 16'hFFFF)) begin
      ovf_d = ovf_q + 16'd1;
    end
  end

  // NOTE: the ring storage has no reset; its contents are meaningless until written.
  always_ff @(posedge clock) begin
    if (wr_ok) begin
      mem_q[wptr_q[ADDR_W-1:0]] <= data_in;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      usedw_q <= '0;
      chunk_q <= '0;
      dout_q  <= '0;
      dv_q    <= 1'b0;
      irq_q   <= 1'b0;
      ovf_q   <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      usedw_q <= usedw_d;
      chunk_q <= chunk_d;
      dout_q  <= dout_d;
      dv_q    <= dv_d;
      irq_q   <= irq_d;
      ovf_q   <= ovf_d;
    end
  end

  assign data_out     = dout_q;
  assign data_valid   = dv_q;
  assign usedw        = usedw_q;
  assign full         = full_w;
  assign empty        = empty_w;
  assign almost_full  = (usedw_q >= AFULL_V);
  assign almost_empty = (usedw_q <= AEMPTY_V);
  assign wptr         = wptr_q;
  assign rptr         = rptr_q;
  assign irq          = irq_q;
  assign ovf_count    = ovf_q;

endmodule

// File: tb/tb_sonic_rx_ring_ctl.sv
// Drop-mode and overwrite-mode rings driven by the same stimulus, each checked
// every cycle against a queue-based model of the ring's rules.
module tb_sonic_rx_ring_ctl;

  localparam int DATA_W = 66;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 256;
  localparam int CHUNK  = 32;

  typedef logic [DATA_W-1:0] blk_t;

  logic clock     = 1'b0;
  logic reset_n   = 1'b0;
  blk_t data_in   = '0;
  logic wrena     = 1'b0;
  logic wrreq     = 1'b0;
  logic rdena     = 1'b0;
  logic rdreq     = 1'b0;
  logic clear_ovf = 1'b0;

  blk_t        d_dout,  o_dout;
  logic        d_dv,    o_dv;
  logic [8:0]  d_usedw, o_usedw;
  logic        d_full,  o_full;
  logic        d_empty, o_empty;
  logic        d_af,    o_af;
  logic        d_ae,    o_ae;
  logic [8:0]  d_wptr,  o_wptr;
  logic [8:0]  d_rptr,  o_rptr;
  logic        d_irq,   o_irq;
  logic [15:0] d_ovf,   o_ovf;

  sonic_rx_ring_ctl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .OVERWRITE(1'b0)) u_drop (
    .clock(clock), .reset_n(reset_n), .data_in(data_in), .wrena(wrena), .wrreq(wrreq),
    .rdena(rdena), .rdreq(rdreq), .clear_ovf(clear_ovf), .data_out(d_dout),
    .data_valid(d_dv), .usedw(d_usedw), .full(d_full), .empty(d_empty),
    .almost_full(d_af), .almost_empty(d_ae), .wptr(d_wptr), .rptr(d_rptr),
    .irq(d_irq), .ovf_count(d_ovf)
  );

  sonic_rx_ring_ctl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .OVERWRITE(1'b1)) u_ovw (
    .clock(clock), .reset_n(reset_n), .data_in(data_in), .wrena(wrena), .wrreq(wrreq),
    .rdena(rdena), .rdreq(rdreq), .clear_ovf(clear_ovf), .data_out(o_dout),
    .data_valid(o_dv), .usedw(o_usedw), .full(o_full), .empty(o_empty),
    .almost_full(o_af), .almost_empty(o_ae), .wptr(o_wptr), .rptr(o_rptr),
    .irq(o_irq), .ovf_count(o_ovf)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input blk_t act, input blk_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference model: the ring is a FIFO queue; pointers are lifetime counts of
  // entries added / removed, wrapped to ADDR_W+1 bits.
  blk_t mq [2][$];
  int   m_wcnt  [2];
  int   m_rcnt  [2];
  int   m_ovf   [2];
  int   m_chunk [2];
  bit   m_irq   [2];
  bit   m_dv    [2];
  blk_t m_dout  [2];
  int   irq_seen [2];

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      mq[m].delete();
      m_wcnt[m]  = 0;
      m_rcnt[m]  = 0;
      m_ovf[m]   = 0;
      m_chunk[m] = 0;
      m_irq[m]   = 1'b0;
      m_dv[m]    = 1'b0;
      m_dout[m]  = '0;
    end
  endtask

  task automatic model_step(input int m, input bit wen, input bit wrq, input bit ren,
                            input bit rrq, input bit clr, input blk_t d, input bit ovw);
    int   sz;
    bit   is_full, rd_ok, wr_try, wr_ok, lost;
    blk_t gone;
    sz      = mq[m].size();
    is_full = (sz == DEPTH);
    rd_ok   = ren && rrq && (sz != 0);
    wr_try  = wen && wrq;
    wr_ok   = wr_try && (!is_full || rd_ok || ovw);
    lost    = wr_try && !wr_ok;
    m_dv[m] = rd_ok;
    if (rd_ok) begin
      m_dout[m] = mq[m].pop_front();
      m_rcnt[m]++;
    end
    if (wr_ok) begin
      if (is_full && !rd_ok) begin
        gone = mq[m].pop_front();
        m_rcnt[m]++;
        lost = 1'b1;
      end
      mq[m].push_back(d);
      m_wcnt[m]++;
    end
    if (clr) m_ovf[m] = 0;
    else if (lost && m_ovf[m] < 65535) m_ovf[m]++;
    m_irq[m] = 1'b0;
    if (!wen) m_chunk[m] = 0;
    else if (wr_ok) begin
      if (m_chunk[m] == CHUNK - 1) begin
        m_irq[m]   = 1'b1;
        m_chunk[m] = 0;
      end else begin
        m_chunk[m]++;
      end
    end
  endtask

  task automatic compare(input string n, input int m, input blk_t dout, input logic dv,
                         input logic [8:0] usedw, input logic full, input logic empty,
                         input logic af, input logic ae, input logic [8:0] wp,
                         input logic [8:0] rp, input logic irq, input logic [15:0] ovf);
    int sz;
    sz = mq[m].size();
    check({n, ".usedw"},  blk_t'(usedw), blk_t'(sz));
    check({n, ".full"},   blk_t'(full),  blk_t'(sz == DEPTH));
    check({n, ".empty"},  blk_t'(empty), blk_t'(sz == 0));
    check({n, ".afull"},  blk_t'(af),    blk_t'(sz >= DEPTH - 8));
    check({n, ".aempty"}, blk_t'(ae),    blk_t'(sz <= 8));
    check({n, ".wptr"},   blk_t'(wp),    blk_t'(m_wcnt[m] % 512));
    check({n, ".rptr"},   blk_t'(rp),    blk_t'(m_rcnt[m] % 512));
    check({n, ".irq"},    blk_t'(irq),   blk_t'(m_irq[m]));
    check({n, ".ovf"},    blk_t'(ovf),   blk_t'(m_ovf[m]));
    check({n, ".dvalid"}, blk_t'(dv),    blk_t'(m_dv[m]));
    check({n, ".dout"},   dout,          m_dout[m]);
  endtask

  task automatic compare_all();
    compare("drop", 0, d_dout, d_dv, d_usedw, d_full, d_empty, d_af, d_ae, d_wptr, d_rptr, d_irq, d_ovf);
    compare("ovw",  1, o_dout, o_dv, o_usedw, o_full, o_empty, o_af, o_ae, o_wptr, o_rptr, o_irq, o_ovf);
  endtask

  task automatic check_reset(input string n, input blk_t dout, input logic dv,
                             input logic [8:0] usedw, input logic full, input logic empty,
                             input logic af, input logic ae, input logic [8:0] wp,
                             input logic [8:0] rp, input logic irq, input logic [15:0] ovf);
    check({n, ".rst_dout"},   dout,          '0);
    check({n, ".rst_dvalid"}, blk_t'(dv),    '0);
    check({n, ".rst_usedw"},  blk_t'(usedw), '0);
    check({n, ".rst_full"},   blk_t'(full),  '0);
    check({n, ".rst_empty"},  blk_t'(empty), blk_t'(1));
    check({n, ".rst_afull"},  blk_t'(af),    '0);
    check({n, ".rst_aempty"}, blk_t'(ae),    blk_t'(1));
    check({n, ".rst_wptr"},   blk_t'(wp),    '0);
    check({n, ".rst_rptr"},   blk_t'(rp),    '0);
    check({n, ".rst_irq"},    blk_t'(irq),   '0);
    check({n, ".rst_ovf"},    blk_t'(ovf),   '0);
  endtask

  // Applies one cycle of stimulus at a falling edge and checks after the next rising edge.
  task automatic cycle(input bit wen, input bit wrq, input bit ren, input bit rrq,
                       input bit clr, input blk_t d);
    wrena     = wen;
    wrreq     = wrq;
    rdena     = ren;
    rdreq     = rrq;
    clear_ovf = clr;
    data_in   = d;
    model_step(0, wen, wrq, ren, rrq, clr, d, 1'b0);
    model_step(1, wen, wrq, ren, rrq, clr, d, 1'b1);
    @(posedge clock);
    @(negedge clock);
    if (d_irq) irq_seen[0]++;
    if (o_irq) irq_seen[1]++;
    compare_all();
  endtask

  task automatic drain();
    for (int i = 0; i < 2 * DEPTH && (mq[0].size() != 0 || mq[1].size() != 0); i++)
      cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, '0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int af_at;
    int w_start, toggles;
    bit msb_prev;
    bit phase;

    model_reset();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check_reset("drop", d_dout, d_dv, d_usedw, d_full, d_empty, d_af, d_ae, d_wptr, d_rptr, d_irq, d_ovf);
    check_reset("ovw",  o_dout, o_dv, o_usedw, o_full, o_empty, o_af, o_ae, o_wptr, o_rptr, o_irq, o_ovf);

    // Fill from reset.
    irq_seen[0] = 0;
    irq_seen[1] = 0;
    af_at = -1;
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, blk_t'(i));
      if (d_af && af_at < 0) af_at = int'(d_usedw);
    end
    check("fill.afull_at", blk_t'(af_at), blk_t'(248));
    check("fill.irq_drop", blk_t'(irq_seen[0]), blk_t'(8));
    check("fill.irq_ovw",  blk_t'(irq_seen[1]), blk_t'(8));
    check("fill.wptr",     blk_t'(d_wptr), blk_t'(9'h100));
    check("fill.full",     blk_t'(d_full), blk_t'(1));
    check("fill.usedw",    blk_t'(d_usedw), blk_t'(256));

    // Overflow: three drops, then a fourth write.
    for (int i = 256; i < 259; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, blk_t'(i));
    check("ovf3.drop_cnt", blk_t'(d_ovf), blk_t'(3));
    check("ovf3.ovw_cnt",  blk_t'(o_ovf), blk_t'(3));
    check("ovf3.usedw",    blk_t'(d_usedw), blk_t'(256));
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, blk_t'(259));
    check("ovf4.drop_cnt", blk_t'(d_ovf), blk_t'(4));
    check("ovf4.ovw_cnt",  blk_t'(o_ovf), blk_t'(4));
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, '0);
      check("drain.drop_data", d_dout, blk_t'(i));
      check("drain.ovw_data",  o_dout, blk_t'(i + 4));
    end
    check("drain.drop_empty", blk_t'(d_empty), blk_t'(1));
    check("drain.ovw_empty",  blk_t'(o_empty), blk_t'(1));

    // Simultaneous write and read on a full ring, then on an empty ring.
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0);
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, blk_t'(1000 + i));
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, blk_t'(5000));
    check("simfull.usedw", blk_t'(d_usedw), blk_t'(256));
    check("simfull.ovf",   blk_t'(d_ovf), '0);
    check("simfull.ovf_o", blk_t'(o_ovf), '0);
    check("simfull.data",  d_dout, blk_t'(1000));
    drain();
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, blk_t'(6000));
    check("simempty.dvalid", blk_t'(d_dv), '0);
    check("simempty.usedw",  blk_t'(d_usedw), blk_t'(1));
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, '0);
    check("simempty.data", d_dout, blk_t'(6000));

    // Random traffic in write-heavy and read-heavy phases.
    w_start  = m_wcnt[0];
    toggles  = 0;
    msb_prev = d_wptr[8];
    for (int k = 0; k < 1000; k++) begin
      phase = ((k / 350) % 2) == 0;
      cycle($urandom_range(0, 15) != 0,
            phase ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 9) == 0),
            $urandom_range(0, 15) != 0,
            phase ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 9) != 0),
            $urandom_range(0, 63) == 0,
            blk_t'({$urandom, $urandom, $urandom}));
      if (d_wptr[8] != msb_prev) toggles++;
      msb_prev = d_wptr[8];
    end
    check("rand.wptr_toggles", blk_t'(toggles), blk_t'(m_wcnt[0] / 256 - w_start / 256));

    // Reset mid-stream with 100 entries and a read just returned.
    drain();
    for (int i = 0; i < 100; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, blk_t'(7000 + i));
    check("midrst.usedw", blk_t'(d_usedw), blk_t'(100));
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, '0);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset("drop", d_dout, d_dv, d_usedw, d_full, d_empty, d_af, d_ae, d_wptr, d_rptr, d_irq, d_ovf);
    check_reset("ovw",  o_dout, o_dv, o_usedw, o_full, o_empty, o_af, o_ae, o_wptr, o_rptr, o_irq, o_ovf);
    model_reset();
    wrena = 1'b0; wrreq = 1'b0; rdena = 1'b0; rdreq = 1'b0; clear_ovf = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);

    // Saturation of the overflow counter, then clear against a drop.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, blk_t'(i));
    for (int i = 0; i < 65535; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, blk_t'(i));
    check("sat.drop_max", blk_t'(d_ovf), blk_t'(16'hFFFF));
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    check("sat.drop_hold", blk_t'(d_ovf), blk_t'(16'hFFFF));
    check("sat.ovw_hold",  blk_t'(o_ovf), blk_t'(16'hFFFF));
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, '0);
    check("clr.drop", blk_t'(d_ovf), '0);
    check("clr.ovw",  blk_t'(o_ovf), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
